// File: rtl/mips_core_pkg.sv
// mips_core_pkg: RRIP FSM states and RRPV constants shared by the replacement block and the SHiP predictor.
package mips_core_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} rrip_state_t;
  function automatic int rrpv_distant(input int m);
    return (1 << m) - 1;
  endfunction
  function automatic int rrpv_long(input int m);
    return (1 << m) - 2;
  endfunction
  function automatic int rrpv_immediate(input int m);
    return (m > 0) ? 0 : 0;
  endfunction
endpackage

// File: rtl/rrip_victim_select_if.sv
// rrip_victim_select_if: victim request/response handshake plus hit/fill update ports of the RRIP array.
interface rrip_victim_select_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int SET_SIZE = 2,
  parameter int M = 2
);
  logic halt;
  logic req_valid;
  logic [INDEX_WIDTH-1:0] req_index;
  logic req_ready;
  logic victim_valid;
  logic [SET_SIZE-1:0] victim_way;
  logic victim_ack;
  logic hit;
  logic [INDEX_WIDTH-1:0] hit_index;
  logic [SET_SIZE-1:0] hit_way;
  logic fill;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [SET_SIZE-1:0] fill_way;
  logic [M-1:0] fill_rrpv;
  modport master (
    output halt, req_valid, req_index, victim_ack, hit, hit_index, hit_way,
           fill, fill_index, fill_way, fill_rrpv,
    input  req_ready, victim_valid, victim_way
  );
  modport slave (
    input  halt, req_valid, req_index, victim_ack, hit, hit_index, hit_way,
           fill, fill_index, fill_way, fill_rrpv,
    output req_ready, victim_valid, victim_way
  );
endinterface

// File: rtl/rrip_way_select.sv
// rrip_way_select: combinational find-first of a DISTANT RRPV across the ways of one set; lowest way wins.
module rrip_way_select
  import mips_core_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_SIZE = $clog2(ASSOCIATIVITY),
  parameter int M = 2
) (
  input  logic [M-1:0]        rrpv_i [ASSOCIATIVITY],
  output logic                found_o,
  output logic [SET_SIZE-1:0] way_o
);
  localparam logic [M-1:0] DISTANT = M'(rrpv_distant(M));
  always_comb begin
    found_o = 1'b0;
    way_o = '0;
    for (int i = ASSOCIATIVITY - 1; i >= 0; i--) begin
      if (rrpv_i[i] == DISTANT) begin
        found_o = 1'b1;
        way_o = SET_SIZE'(i);
      end
    end
  end
endmodule

// File: rtl/rrip_victim_select.sv
// rrip_victim_select: per-set RRPV array with hit/fill updates and a multi-cycle aging victim scan.
// Define RRIP_FP_EN for frequency-priority hit promotion (decrement) instead of hit-priority (reset to IMMEDIATE).
module rrip_victim_select
  import mips_core_pkg::*;
#(
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_SIZE = $clog2(ASSOCIATIVITY),
  parameter int INDEX_WIDTH = 4,
  parameter int DEPTH = 2**INDEX_WIDTH,
  parameter int M = 2
) (
  input logic clk,
  input logic rst,
  rrip_victim_select_if.slave bus
);
  localparam logic [M-1:0] DISTANT = M'(rrpv_distant(M));
  localparam logic [M-1:0] IMMEDIATE = M'(rrpv_immediate(M));
  rrip_state_t state_q;
  logic [INDEX_WIDTH-1:0] scan_index_q;
  logic [SET_SIZE-1:0] victim_way_q, found_way;
  logic victim_valid_q, found, age;
  logic [M-1:0] rrpv_q [ASSOCIATIVITY][DEPTH];
  logic [M-1:0] rrpv_d [ASSOCIATIVITY][DEPTH];
  logic [M-1:0] scan_set [ASSOCIATIVITY];
  assign age = (state_q == SCAN) && !found;
  for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way
    assign scan_set[w] = rrpv_q[w][scan_index_q];
    for (genvar s = 0; s < DEPTH; s++) begin : g_set
      logic [M-1:0] cur, hit_val;
      logic fill_hit, hit_hit;
      assign cur = rrpv_q[w][s];
`ifdef RRIP_FP_EN
      assign hit_val = (cur == IMMEDIATE) ? IMMEDIATE : cur - 1'b1;
`else
      assign hit_val = IMMEDIATE;
`endif
      assign fill_hit = bus.fill && bus.fill_way == SET_SIZE'(w) && bus.fill_index == INDEX_WIDTH'(s);
      assign hit_hit = bus.hit && bus.hit_way == SET_SIZE'(w) && bus.hit_index == INDEX_WIDTH'(s);
      // fill beats hit beats aging, so untargeted ways of the scanned set still age
      assign rrpv_d[w][s] = fill_hit ? bus.fill_rrpv :
                            hit_hit ? hit_val :
                            (age && scan_index_q == INDEX_WIDTH'(s)) ? cur + 1'b1 : cur;
    end
  end
  rrip_way_select #(
    .ASSOCIATIVITY(ASSOCIATIVITY),
    .SET_SIZE(SET_SIZE),
    .M(M)
  ) u_sel (
    .rrpv_i(scan_set),
    .found_o(found),
    .way_o(found_way)
  );
  // DONE spends one cycle presenting the registered way before raising valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scan_index_q <= '0;
      victim_way_q <= '0;
      victim_valid_q <= 1'b0;
      for (int w = 0; w < ASSOCIATIVITY; w++)
        for (int s = 0; s < DEPTH; s++)
          rrpv_q[w][s] <= DISTANT;
    end else if (!bus.halt) begin
      for (int w = 0; w < ASSOCIATIVITY; w++)
        for (int s = 0; s < DEPTH; s++)
          rrpv_q[w][s] <= rrpv_d[w][s];
      case (state_q)
        IDLE: if (bus.req_valid) begin
          scan_index_q <= bus.req_index;
          state_q <= SCAN;
        end
        SCAN: if (found) begin
          victim_way_q <= found_way;
          state_q <= DONE;
        end
        DONE: if (!victim_valid_q) victim_valid_q <= 1'b1;
          else if (bus.victim_ack) begin
            victim_valid_q <= 1'b0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_way = victim_way_q;
endmodule

// File: tb/tb_rrip_victim_select.sv
// tb_rrip_victim_select: directed plus randomized checks of the RRIP victim selector against a set-level model.
module tb_rrip_victim_select;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int DIST = 3;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int model [WAYS][SETS];
  rrip_victim_select_if #(.INDEX_WIDTH(4), .SET_SIZE(2), .M(2)) bus ();
  rrip_victim_select #(
    .ASSOCIATIVITY(4), .SET_SIZE(2), .INDEX_WIDTH(4), .DEPTH(16), .M(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clear_inputs();
    bus.halt = 0; bus.req_valid = 0; bus.req_index = 0; bus.victim_ack = 0;
    bus.hit = 0; bus.hit_index = 0; bus.hit_way = 0;
    bus.fill = 0; bus.fill_index = 0; bus.fill_way = 0; bus.fill_rrpv = 0;
  endtask
  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++)
        model[w][s] = DIST;
  endtask
  function automatic int promote(input int v);
`ifdef RRIP_FP_EN
    return (v > 0) ? v - 1 : 0;
`else
    return (v >= 0) ? 0 : 0;
`endif
  endfunction
  task automatic chk_set(input string tag, input int idx);
    for (int w = 0; w < WAYS; w++)
      chk($sformatf("%s set%0d way%0d", tag, idx, w), 32'(dut.rrpv_q[w][idx]), 32'(model[w][idx]));
  endtask
  task automatic chk_all(input string tag);
    for (int s = 0; s < SETS; s++) chk_set(tag, s);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, 32'(bus.req_ready), 1);
    chk({tag, " valid"}, 32'(bus.victim_valid), 0);
    chk({tag, " way"}, 32'(bus.victim_way), 0);
  endtask
  task automatic do_fill(input int idx, input int way, input int v);
    bus.fill = 1; bus.fill_index = 4'(idx); bus.fill_way = 2'(way); bus.fill_rrpv = 2'(v);
    tick();
    bus.fill = 0;
    model[way][idx] = v;
  endtask
  task automatic do_hit(input int idx, input int way);
    bus.hit = 1; bus.hit_index = 4'(idx); bus.hit_way = 2'(way);
    tick();
    bus.hit = 0;
    model[way][idx] = promote(model[way][idx]);
  endtask
  task automatic do_hit_fill(input int idx, input int way, input int v);
    bus.hit = 1; bus.hit_index = 4'(idx); bus.hit_way = 2'(way);
    bus.fill = 1; bus.fill_index = 4'(idx); bus.fill_way = 2'(way); bus.fill_rrpv = 2'(v);
    tick();
    bus.hit = 0; bus.fill = 0;
    model[way][idx] = v;
  endtask
  task automatic fill_set(input int idx, input int v0, input int v1, input int v2, input int v3);
    do_fill(idx, 0, v0); do_fill(idx, 1, v1); do_fill(idx, 2, v2); do_fill(idx, 3, v3);
  endtask
  // Victim is the lowest way holding the set maximum; the set ages by DIST-max passes first.
  task automatic predict(input int idx, output int passes, output int way);
    int mx;
    mx = 0;
    for (int w = 0; w < WAYS; w++) if (model[w][idx] > mx) mx = model[w][idx];
    passes = DIST - mx;
    way = 0;
    for (int w = WAYS - 1; w >= 0; w--) if (model[w][idx] == mx) way = w;
    for (int w = 0; w < WAYS; w++) model[w][idx] += passes;
  endtask
  task automatic accept(input int idx);
    chk("ready before request", 32'(bus.req_ready), 1);
    bus.req_valid = 1; bus.req_index = 4'(idx);
    tick();
    bus.req_valid = 0;
    chk("ready while busy", 32'(bus.req_ready), 0);
  endtask
  task automatic wait_victim(input string tag, input int exp_lat, input int exp_way);
    int lat;
    lat = 0;
    while (!bus.victim_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " victim_way"}, 32'(bus.victim_way), 32'(exp_way));
  endtask
  task automatic ack_victim(input int delay, input int exp_way);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("valid held", 32'(bus.victim_valid), 1);
      chk("way held", 32'(bus.victim_way), 32'(exp_way));
    end
    bus.victim_ack = 1;
    tick();
    bus.victim_ack = 0;
    chk("valid after ack", 32'(bus.victim_valid), 0);
    chk("ready after ack", 32'(bus.req_ready), 1);
  endtask
  task automatic request(input string tag, input int idx, input int delay);
    int passes, way;
    predict(idx, passes, way);
    accept(idx);
    wait_victim(tag, 2 + passes, way);
    ack_victim(delay, way);
    chk_set(tag, idx);
  endtask
  initial begin
    int passes, way, op, idx, wy, v;
    clear_inputs();
    model_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_idle("reset");
    chk_all("reset array");
    request("t1 fresh set", 5, 0);
    fill_set(5, 2, 2, 2, 2);
    chk_set("t2 filled", 5);
    request("t2 one pass", 5, 0);
    fill_set(7, 0, 1, 0, 0);
    request("t3 two passes", 7, 1);
    do_hit(3, 2);
    chk_set("t4 first hit", 3);
    do_hit(3, 2);
    chk_set("t4 second hit", 3);
    fill_set(4, 0, 0, 0, 0);
    do_hit_fill(4, 1, 2);
    chk_set("t5 hit+fill idle", 4);
    accept(4);
    bus.hit = 1; bus.hit_index = 4; bus.hit_way = 1;
    bus.fill = 1; bus.fill_index = 4; bus.fill_way = 1; bus.fill_rrpv = 2;
    tick();
    bus.hit = 0; bus.fill = 0;
    for (int w = 0; w < WAYS; w++) model[w][4] = (w == 1) ? 2 : model[w][4] + 1;
    chk_set("t5 hit+fill scan", 4);
    predict(4, passes, way);
    wait_victim("t5 scan", 2 + passes, way);
    ack_victim(0, way);
    chk_set("t5 done", 4);
    fill_set(9, 0, 0, 0, 0);
    accept(9);
    tick();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    chk_idle("t6 rst in scan");
    chk_all("t6 rst in scan array");
    fill_set(9, 0, 1, 0, 0);
    accept(9);
    bus.halt = 1; rst = 1;
    tick();
    bus.halt = 0; rst = 0;
    model_reset();
    chk_idle("t6 rst with halt");
    chk_all("t6 rst with halt array");
    fill_set(10, 0, 0, 0, 0);
    accept(10);
    bus.halt = 1;
    bus.fill = 1; bus.fill_index = 10; bus.fill_way = 0; bus.fill_rrpv = 3;
    bus.hit = 1; bus.hit_index = 2; bus.hit_way = 1;
    bus.req_valid = 1; bus.req_index = 2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6 halt ready", 32'(bus.req_ready), 0);
      chk("t6 halt valid", 32'(bus.victim_valid), 0);
    end
    clear_inputs();
    chk_set("t6 halt scanned", 10);
    chk_set("t6 halt hit target", 2);
    predict(10, passes, way);
    wait_victim("t6 after halt", 2 + passes, way);
    bus.halt = 1; bus.victim_ack = 1;
    tick(); tick();
    chk("t6 halt holds valid", 32'(bus.victim_valid), 1);
    chk("t6 halt holds way", 32'(bus.victim_way), 32'(way));
    bus.halt = 0; bus.victim_ack = 0;
    ack_victim(0, way);
    chk_set("t6 halt done", 10);
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 3));
      wy = int'($urandom_range(0, 3));
      v = int'($urandom_range(0, 3));
      case (op)
        0: do_fill(idx, wy, v);
        1: do_hit(idx, wy);
        2: do_hit_fill(idx, wy, v);
        default: request("random request", idx, int'($urandom_range(0, 2)));
      endcase
      chk_set("random op", idx);
    end
    chk_all("final array");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rrip_victim_select.md
# rrip_victim_select

Per-set RRIP replacement-state array and victim finder for the set-associative caches. It stores an M-bit RRPV for every line and applies hit promotions. It writes the insertion RRPV produced by the SHiP predictor on each fill. On request it runs a multi-cycle aging scan to nominate the eviction way, which the cache controller and the SHiP predictor consume as `evict_way`.

## Interface
- `ASSOCIATIVITY`, 4, number of ways
- `SET_SIZE`, 2, way-index width, $clog2(ASSOCIATIVITY)
- `INDEX_WIDTH`, 4, set-index width
- `DEPTH`, 16, number of sets, 2**INDEX_WIDTH
- `M`, 2, RRPV width
- `clk` in 1: clock; the block uses one clock.
- `rst` in 1: synchronous, active-high reset.
- `halt` in 1: freezes the FSM, all array updates and outputs.
- `req_valid` in 1: victim request.
- `req_index` in INDEX_WIDTH: set to search.
- `req_ready` out 1: high only in IDLE.
- `victim_valid` out 1: victim nominated, held until acked.
- `victim_way` out SET_SIZE: nominated way.
- `victim_ack` in 1: consumer accepted the victim.
- `hit` in 1: cache hit update.
- `hit_index` in INDEX_WIDTH
- `hit_way` in SET_SIZE
- `fill` in 1: line installed.
- `fill_index` in INDEX_WIDTH
- `fill_way` in SET_SIZE
- `fill_rrpv` in M: insertion value from SHiP `RRPV`.

## Operation
- Constants: DISTANT = 2**M-1, IMMEDIATE = 0.
- Array `rrpv[ASSOCIATIVITY][DEPTH]`. Reset sets every entry to DISTANT.
- FSM has states IDLE, SCAN and DONE. Reset state is IDLE.
  - **IDLE:** when `req_valid` is high, latch `req_index` into `scan_index` and go to SCAN. `req_valid` is ignored in every other state.
  - **SCAN:** read all ways of `scan_index`.
    - If any way equals DISTANT, register the lowest-numbered such way into `victim_way` and go to DONE.
    - Otherwise, increment every way of that set by 1 and stay in SCAN. No entry is at DISTANT, so no saturation is needed.
    - Worst case is DISTANT aging cycles.
  - **DONE:** `victim_valid`=1. When `victim_ack` is high, go to IDLE. `victim_valid` drops in the next cycle.
- Hit: `rrpv[hit_way][hit_index]` <= IMMEDIATE.
- Fill: `rrpv[fill_way][fill_index]` <= `fill_rrpv`.
- Write priority per entry in one cycle, highest first: fill, then hit, then aging increment.
  - Aging still applies to the untargeted ways of the set.
  - A hit or fill landing during SCAN is visible to the next scan cycle.
- `halt` high: no array write, no state change, outputs hold.
- Reset mid-operation (any state): next cycle is IDLE with `victim_valid`=0, `victim_way`=0 and the whole array at DISTANT.
- Reset values: `req_ready`=1, `victim_valid`=0, `victim_way`=0.

## Timing
- Request accepted at edge 0, in IDLE with `req_valid` high.
- First SCAN evaluation happens in cycle 1.
- With no aging, `victim_valid` rises after edge 2. Each aging pass adds 1 cycle, so maximum latency is 2+DISTANT.
- `victim_way` is registered and stable while `victim_valid` is high.
- Hit and fill writes are visible one cycle after the edge.
- Back-to-back: an ack in DONE returns to IDLE, and the earliest next request is accepted the cycle after.

## Configuration
- `RRIP_FP_EN` defined: frequency-priority promotion. A hit decrements the RRPV by 1, saturating at 0.
- `RRIP_FP_EN` undefined: hit-priority promotion. A hit sets the RRPV to IMMEDIATE.
- Fill and aging behaviour is identical in both builds.

## Structure
- Shared package `mips_core_pkg` holds:
  - `rrip_state_t` enum {IDLE, SCAN, DONE}
  - RRPV constant functions of M: DISTANT, LONG = 2**M-2, IMMEDIATE.
- The SHiP predictor reuses the same constants.
- Sub-module `rrip_way_select`: combinational find-first.
  - Inputs: ASSOCIATIVITY M-bit RRPVs.
  - Outputs: `found` and `way`, lowest index wins.

## Test plan
Configuration for all cases: ASSOCIATIVITY=4, M=2, DEPTH=16.
1. After reset, request set 5, ack on the first cycle `victim_valid` is high → `victim_valid` rises after edge 2 with `victim_way`=0, and array set 5 stays {3,3,3,3}.
2. Fill ways 0–3 of set 5 with rrpv 2, then request set 5 → one aging cycle makes the set {3,3,3,3}, `victim_way`=0, valid after edge 3.
3. Fill ways 0–3 of set 7 with {0,1,0,0}, then request set 7 → two aging cycles leave {2,3,2,2}, `victim_way`=1, valid after edge 4.
4. Hit `rrpv`=3 entry way 2, set 3:
   - Without `RRIP_FP_EN` → 0.
   - With `RRIP_FP_EN` → 2, then a second hit → 1.
5. Same cycle: hit and fill both target way 1, set 4 with `fill_rrpv`=2 → entry is 2. Repeat during SCAN of set 4 → other ways age and way 1 = 2.
6. Assert `rst` while in SCAN, and separately with `halt` high → next cycle IDLE, `victim_valid`=0, all entries 3. With `halt` alone for 3 cycles, state and array are unchanged.
